// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates the single register-file write port between the
// retire pipeline and a small in-order FIFO of MUL/DIV results.
// Optional starvation guard (wait counter, FORCE state, PIPE_HOLD) is compiled
// in when the macro WB_ARB_STARVE_GUARD_EN is defined.
module wb_port_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PIPE_VALID,
    input  logic [4:0]  PIPE_DES,
    input  logic [31:0] PIPE_DATA,
    input  logic        MD_VALID,
    input  logic [4:0]  MD_DES,
    input  logic [31:0] MD_DATA,
    output logic        MD_READY,
    input  logic [4:0]  RS1_SEL,
    input  logic [4:0]  RS2_SEL,
    output logic        RS1_PENDING,
    output logic        RS2_PENDING,
    output logic        WB_VALID,
    output logic [4:0]  WB_DES,
    output logic [31:0] WB_DATA,
    output logic        PIPE_HOLD
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        STARVE_LIMIT < 1) begin : g_bad_param
        $error("wb_port_arbiter: FIFO_DEPTH must be a power of two in 2..8, STARVE_LIMIT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_FORCE
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          rd_ptr_q, wr_ptr_q;
    logic [FIFO_DEPTH-1:0]  vld_q;
    logic [4:0]             mem_des_q  [FIFO_DEPTH];
    logic [31:0]            mem_data_q [FIFO_DEPTH];
    logic                   wb_valid_q, wb_md_q;
    logic [4:0]             wb_des_q;
    logic [31:0]            wb_data_q;

    logic hold, pipe_grant, drain, push, rs1_hit, rs2_hit;

    // Handshake and grant decisions for this cycle
    always_comb begin
        MD_READY   = (count_q < CW'(FIFO_DEPTH));
        pipe_grant = PIPE_VALID && (PIPE_DES != '0) && !hold;
        drain      = (count_q != '0) && !pipe_grant;
        push       = MD_VALID && MD_READY && (MD_DES != '0);
        unique case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int unsigned WW = $clog2(STARVE_LIMIT) + 1;
    logic [WW-1:0] wait_q, wait_d;

    // Wait counter: counts PEND cycles where the head is passed over
    always_comb begin
        wait_d = '0;
        if (state_q == S_PEND && !drain && wait_q != WW'(STARVE_LIMIT - 1))
            wait_d = wait_q + 1'b1;
    end

    // Wait counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) wait_q <= '0;
        else     wait_q <= wait_d;
    end
`endif

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (push) state_d = S_PEND;
            S_PEND: begin
                if (count_d == '0) state_d = S_IDLE;
`ifdef WB_ARB_STARVE_GUARD_EN
                else if (!drain && wait_q == WW'(STARVE_LIMIT - 1)) state_d = S_FORCE;
`endif
            end
            S_FORCE: state_d = (count_d == '0) ? S_IDLE : S_PEND;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
`ifdef WB_ARB_STARVE_GUARD_EN
        hold = (state_q == S_FORCE);
`else
        hold = 1'b0;
`endif
        PIPE_HOLD = hold;
    end

    // FIFO control and registered write port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            vld_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_md_q    <= 1'b0;
            wb_des_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            count_q    <= count_d;
            wb_valid_q <= pipe_grant || drain;
            wb_md_q    <= drain;
            if (push) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pipe_grant) begin
                wb_des_q  <= PIPE_DES;
                wb_data_q <= PIPE_DATA;
            end else if (drain) begin
                wb_des_q        <= mem_des_q[rd_ptr_q];
                wb_data_q       <= mem_data_q[rd_ptr_q];
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage, qualified by vld_q so no reset needed
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_des_q[wr_ptr_q]  <= MD_DES;
            mem_data_q[wr_ptr_q] <= MD_DATA;
        end
    end

    // Pending check: buffered entries plus an MD write currently on the port
    always_comb begin
        rs1_hit = wb_valid_q && wb_md_q && (wb_des_q == RS1_SEL);
        rs2_hit = wb_valid_q && wb_md_q && (wb_des_q == RS2_SEL);
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_q[PW'(i)] && mem_des_q[PW'(i)] == RS1_SEL) rs1_hit = 1'b1;
            if (vld_q[PW'(i)] && mem_des_q[PW'(i)] == RS2_SEL) rs2_hit = 1'b1;
        end
        RS1_PENDING = rs1_hit && (RS1_SEL != '0);
        RS2_PENDING = rs2_hit && (RS2_SEL != '0);
    end

    assign WB_VALID = wb_valid_q;
    assign WB_DES   = wb_des_q;
    assign WB_DATA  = wb_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// each cycle's write-port result; a monitor pops and compares after each edge.
module tb_wb_port_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PIPE_VALID = 1'b0, MD_VALID = 1'b0;
    logic [4:0]  PIPE_DES = '0, MD_DES = '0, RS1_SEL = '0, RS2_SEL = '0;
    logic [31:0] PIPE_DATA = '0, MD_DATA = '0;
    logic        MD_READY, RS1_PENDING, RS2_PENDING, WB_VALID, PIPE_HOLD;
    logic [4:0]  WB_DES;
    logic [31:0] WB_DATA;

    wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .PIPE_VALID(PIPE_VALID), .PIPE_DES(PIPE_DES), .PIPE_DATA(PIPE_DATA),
        .MD_VALID(MD_VALID), .MD_DES(MD_DES), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
        .RS1_SEL(RS1_SEL), .RS2_SEL(RS2_SEL),
        .RS1_PENDING(RS1_PENDING), .RS2_PENDING(RS2_PENDING),
        .WB_VALID(WB_VALID), .WB_DES(WB_DES), .WB_DATA(WB_DATA),
        .PIPE_HOLD(PIPE_HOLD)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic v; logic [4:0] des; logic [31:0] data; } wb_t;
    typedef struct packed { logic [4:0] des; logic [31:0] data; } ent_t;

    wb_t         exp_q[$];
    ent_t        buf_q[$];
    int          n_cmp = 0, n_err = 0;
    bit          running = 0;
    logic [4:0]  last_des;
    logic [31:0] last_data;
    bit          pres_md, force_m;
    logic [4:0]  pres_des;
    int          wait_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_pending(input logic [4:0] sel);
        if (sel == 0) return 0;
        foreach (buf_q[i]) if (buf_q[i].des == sel) return 1;
        return pres_md && (pres_des == sel);
    endfunction

    task automatic model_reset();
        buf_q.delete();
        exp_q.delete();
        last_des = '0; last_data = '0;
        pres_md = 0; pres_des = '0; force_m = 0; wait_m = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_md_ready", MD_READY, 1);
        chk("rst_wb_valid", WB_VALID, 0);
        chk("rst_wb_des", WB_DES, 0);
        chk("rst_wb_data", WB_DATA, 0);
        chk("rst_pipe_hold", PIPE_HOLD, 0);
        chk("rst_rs1_pending", RS1_PENDING, 0);
    endtask

    // One cycle: drive inputs, check combinational outputs, predict the write
    task automatic step(input bit pv, input logic [4:0] pd, input logic [31:0] pdat,
                        input bit mv, input logic [4:0] md, input logic [31:0] mdat,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit ready, hold, pipe_ok, had, drained;
        wb_t w;
        ent_t e;
        @(negedge CLK);
        PIPE_VALID = pv; PIPE_DES = pd; PIPE_DATA = pdat;
        MD_VALID = mv; MD_DES = md; MD_DATA = mdat;
        RS1_SEL = r1; RS2_SEL = r2;
        #1;
        ready = (buf_q.size() < DEPTH);
        hold  = force_m;
        chk("md_ready", MD_READY, ready);
        chk("pipe_hold", PIPE_HOLD, hold);
        chk("rs1_pending", RS1_PENDING, model_pending(r1));
        chk("rs2_pending", RS2_PENDING, model_pending(r2));
        pipe_ok = pv && (pd != 0) && !hold;
        had     = (buf_q.size() > 0);
        drained = 0;
        w = '{1'b0, last_des, last_data};
        if (pipe_ok) begin
            w = '{1'b1, pd, pdat};
        end else if (had) begin
            e = buf_q.pop_front();
            w = '{1'b1, e.des, e.data};
            drained = 1;
        end
        if (w.v) begin last_des = w.des; last_data = w.data; end
        exp_q.push_back(w);
        pres_md  = drained;
        pres_des = w.des;
        if (mv && ready && md != 0) buf_q.push_back(ent_t'{md, mdat});
`ifdef WB_ARB_STARVE_GUARD_EN
        if (hold) begin
            force_m = 0; wait_m = 0;
        end else if (had && !drained) begin
            wait_m++;
            if (wait_m == LIMIT) begin force_m = 1; wait_m = 0; end
        end else begin
            wait_m = 0;
        end
`endif
    endtask

    task automatic idle(input int n, input logic [4:0] r1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    task automatic reset_mid(input logic [4:0] sel);
        @(negedge CLK);
        PIPE_VALID = 0; MD_VALID = 0; RS1_SEL = sel; RST = 1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 0;
        exp_q.push_back('{1'b0, 5'd0, 32'd0});
    endtask

    // Monitor: one expected port state per cycle
    initial begin
        wb_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (running && !RST) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wb_underflow: got WB_VALID=%0d expected no unscheduled cycle", WB_VALID);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_valid", WB_VALID, e.v);
                    chk("wb_des", WB_DES, e.des);
                    chk("wb_data", WB_DATA, e.data);
                end
            end
        end
    end

    initial begin
        model_reset();
        #1;
        RS1_SEL = 5'd5;
        check_reset_outputs();
        @(negedge CLK);
        @(negedge CLK);
        RST = 0;
        exp_q.push_back('{1'b0, 5'd0, 32'd0});
        running = 1;

        // Single MD result into an idle pipeline, watched by RS1
        step(0, 0, 0, 1, 5, 32'hA5A5_A5A5, 5, 0);
        idle(3, 5);

        // Pipeline and MD in the same cycle: pipeline first, MD next
        step(1, 3, 32'h11, 1, 4, 32'h22, 3, 4);
        idle(3, 4);

        // Zero destinations never write and never buffer
        step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
        step(1, 0, 32'h1234, 1, 0, 32'h5678, 0, 0);
        idle(2, 0);

        // Continuous pipeline writes with 5 MD offers: fill, starve, (force)
        for (int k = 0; k < 30; k++)
            step(1, 5'(1 + k % 31), 32'h1000 + 32'(k), k < 5, 5'(10 + k), 32'h2000 + 32'(k), 5'(10 + k % 5), 12);
        idle(6, 10);

        // Three entries buffered, then an asynchronous reset mid-cycle
        for (int k = 0; k < 3; k++)
            step(1, 7, 32'h700 + 32'(k), 1, 5'(9 + k), 32'h900 + 32'(k), 9, 10);
        reset_mid(9);
        idle(3, 9);

        // Randomized traffic in segments of varying pipeline load
        for (int seg = 0; seg < 10; seg++) begin
            int unsigned load = (seg % 2 == 0) ? 15 : 6;
            for (int c = 0; c < 40; c++) begin
                bit pv = ($urandom_range(0, 15) < load);
                logic [4:0] pd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                bit mv = ($urandom_range(0, 2) != 0);
                logic [4:0] md = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                step(pv, pd, $urandom, mv, md, $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        idle(8, 0);

        @(posedge CLK);
        #2;
        running = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
